i2c_cmd_sequencer: RTL

//  Command queue and sequencer directly upstream of the I2C_master core. Software or

---
 rtl/i2c_seq_pkg.sv | 22 ++
 rtl/i2c_cmd_sequencer_if.sv | 22 ++
 rtl/i2c_seq_fifo.sv | 46 ++++
 rtl/i2c_cmd_sequencer.sv | 130 +++++++++++++
 4 files changed

// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C command sequencer: FSM states, master status bit
// positions and the width of a queued command entry ({read, control word}).
package i2c_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_CHECK,
        S_GAP,
        S_RESP
    } seq_state_t;

    localparam int BUSY  = 31;
    localparam int ANACK = 30;
    localparam int DNACK = 29;
    localparam int RD    = 28;

    localparam int ENTRY_W = 33;

endpackage

// File: rtl/i2c_cmd_sequencer_if.sv
// Command push and response channels of the I2C command sequencer.
// A command transfers on a clock edge where cmd_valid && cmd_ready; cmd_data/cmd_read
// must be stable while cmd_valid is high. rsp_valid is a one-cycle pulse with no back-pressure.
interface i2c_cmd_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_data;
    logic        cmd_read;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_err;

    modport master (
        output cmd_valid, cmd_data, cmd_read,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_data, cmd_read,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/i2c_seq_fifo.sv
// Synchronous command FIFO, DEPTH entries of {read, control word}.
// Pushes into a full FIFO and pops from an empty one are ignored.
module i2c_seq_fifo
    import i2c_seq_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [ENTRY_W-1:0] din,
    output logic [ENTRY_W-1:0] dout,
    output logic               full,
    output logic               empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW:0]        wptr;
    logic [AW:0]        rptr;
    logic               do_push;
    logic               do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty   = (wptr == rptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Queues I2C master commands and issues them one at a time, returning one response each.
// Optional retry-after-NACK with an idle gap is built when I2C_SEQ_RETRY_EN is defined.
module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int MAX_RETRY = 3,
    parameter int RETRY_GAP = 200
) (
    input  logic               sys_clock,
    input  logic               reset,
    i2c_cmd_sequencer_if.slave bus,
    output logic [31:0]        ctrl_data,
    output logic               wr_ctrl,
    output logic               read,
    input  logic [31:0]        status,
    output logic               seq_busy,
    output logic [7:0]         err_count,
    output seq_state_t         dbg_state
);
    seq_state_t         state;
    logic [ENTRY_W-1:0] head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic [1:0]         err_now;
    logic               rsp_valid_q;
    logic [7:0]         rsp_data_q;
    logic [1:0]         rsp_err_q;
    logic               unused_status;

`ifdef I2C_SEQ_RETRY_EN
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam int GW = $clog2(RETRY_GAP + 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [GW-1:0] GAP_LAST  = GW'(RETRY_GAP - 1);
    logic [RW-1:0] retry_cnt;
    logic [GW-1:0] gap_cnt;
`else
    localparam int unused_cfg = MAX_RETRY + RETRY_GAP;
`endif

    assign err_now       = {status[ANACK], status[DNACK]};
    assign pop           = (state == S_IDLE) && !fifo_empty && !status[BUSY];
    assign unused_status = ^status[RD:8];

    i2c_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (sys_clock),
        .rst   (reset),
        .push  (bus.cmd_valid),
        .pop   (pop),
        .din   ({bus.cmd_read, bus.cmd_data}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.cmd_ready = !fifo_full;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign seq_busy      = !fifo_empty || (state != S_IDLE);
    assign dbg_state     = state;

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            ctrl_data   <= '0;
            wr_ctrl     <= 1'b0;
            read        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= '0;
            err_count   <= '0;
`ifdef I2C_SEQ_RETRY_EN
            retry_cnt   <= '0;
            gap_cnt     <= '0;
`endif
        end else begin
            wr_ctrl     <= 1'b0;
            rsp_valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        ctrl_data <= head[31:0];
                        read      <= head[32];
`ifdef I2C_SEQ_RETRY_EN
                        retry_cnt <= '0;
`endif
                        state     <= S_ISSUE;
                    end
                end
                // Never pulse wr_ctrl into a busy master.
                S_ISSUE: begin
                    if (!status[BUSY]) begin
                        wr_ctrl <= 1'b1;
                        state   <= S_WAIT_HI;
                    end
                end
                S_WAIT_HI: if (status[BUSY])  state <= S_WAIT_LO;
                S_WAIT_LO: if (!status[BUSY]) state <= S_CHECK;
                S_CHECK: begin
`ifdef I2C_SEQ_RETRY_EN
                    if ((err_now != 2'b00) && (retry_cnt < RETRY_MAX)) begin
                        retry_cnt <= retry_cnt + RW'(1);
                        gap_cnt   <= '0;
                        state     <= S_GAP;
                    end else
`endif
                    begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= read ? status[7:0] : 8'h00;
                        rsp_err_q   <= err_now;
                        if ((err_now != 2'b00) && (err_count != 8'hFF))
                            err_count <= err_count + 8'd1;
                        state       <= S_RESP;
                    end
                end
`ifdef I2C_SEQ_RETRY_EN
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) state <= S_ISSUE;
                    else                     gap_cnt <= gap_cnt + GW'(1);
                end
`endif
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
